countdown_timer: RTL and testbench
==================================

COUNTDOWN_TIMER -- requirements
Module: countdown_timer

Interface
REQ-001 SHALL have port clk  in  1  1 kHz system clock; all logic on rising edge.
REQ-002 SHALL have port rst  in  1  synchronous, active-high reset.
REQ-003 SHALL have port start  in  1  level; rising edge toggles run/stop.
REQ-004 SHALL have port load  in  1  level; high for one or more cycles loads preset.
REQ-005 SHALL have port preset  in  24  BCD HHMMSS, [23:20]=h_ten ... [3:0]=s_one; centiseconds load as 00.
REQ-006 SHALL have port seg_data  out  8  registered 7-segment pattern of the currently scanned digit.
REQ-007 SHALL have port seg_com  out  8  registered active-low digit select, one-hot-low.
REQ-008 SHALL have port running  out  1  high while counting down.
REQ-009 SHALL have port alarm  out  1  high from expiry until cleared.

Function
REQ-010 SHALL hold eight BCD digits h_ten,h_one,m_ten,m_one,s_ten,s_one,cs_ten,cs_one; limits 9,9,5,9,5,9,9,9.
REQ-011 SHALL generate a centisecond tick every 10 clk cycles from a 4-bit prescaler (0..9) that counts only while running.
REQ-012 SHALL, on each tick while running, decrement the count by 1 cs with borrow ripple; a digit at 0 reloads its limit and borrows from the next digit.
REQ-013 SHALL, on the tick that makes the count 00:00:00:00, clear running and set alarm in the same cycle.
REQ-014 SHALL detect the start edge with a registered previous value; each rising edge is one press.
REQ-015 SHALL, on a press with alarm=1, clear alarm and leave running=0.
REQ-016 SHALL, on a press with alarm=0 and a nonzero count, toggle running.
REQ-017 SHALL ignore a press while the count is zero and alarm=0.
REQ-018 SHALL, while load=1, copy preset into the HH:MM:SS digits, zero cs digits, clear running, alarm and prescaler.
REQ-019 SHALL clamp any preset digit above its limit to that limit (e.g. m_ten=7 loads as 5).
REQ-020 SHALL give load priority over a simultaneous start edge; that edge is discarded.
REQ-021 SHALL scan digits with a 3-bit free-running counter, one digit per clk, order h_ten..cs_one.
REQ-022 SHALL drive seg_com 8'b0111_1111 for h_ten, shifting the zero right per digit to 8'b1111_1110 for cs_one.
REQ-023 SHALL register seg_data and seg_com together, one cycle after the scan counter value.
REQ-024 SHALL hold the count unchanged while stopped (paused value is kept, not cleared).

Reset
REQ-025 SHALL, with rst=1 at a clk edge, set all digits 0, prescaler 0, scan counter 0, running 0, alarm 0, previous-start 0.
REQ-026 SHALL reset seg_com to 8'hFF and seg_data to 8'h00.
REQ-027 SHALL give rst priority over load and start, including mid-countdown.

Configuration
REQ-028 SHALL, with ALARM_BLINK_EN defined, force seg_com to 8'hFF during alternate 250-cycle intervals while alarm=1 (2 Hz blink, phase counter cleared when alarm sets).
REQ-029 SHALL, without ALARM_BLINK_EN, keep the display scanning steadily during alarm with no blink counter present.

Structure
REQ-030 SHALL take digit limits, prescaler terminal count (9), seg_com patterns and blank code from the shared stopwatch package.
REQ-031 SHALL instantiate the existing seg_decode sub-module eight times, one per digit; no other sub-modules.

Verification
REQ-032 SHALL cover: rst, load preset=24'h000001, press start -> running=1; count 00:00:00:99 after 10 cycles; alarm=1, running=0 after 1000 cycles.
REQ-033 SHALL cover: preset 24'h010000, run to 01:00:00:00 minus 1 cs -> digits 00:59:59:99 (full borrow ripple).
REQ-034 SHALL cover: pause after 35 ticks from 00:00:10:00, hold 200 cycles -> count stays 00:00:09:65; second press resumes.
REQ-035 SHALL cover: load and start edge in same cycle -> running=0, preset loaded; preset m_ten=7 -> m_ten reads 5.
REQ-036 SHALL cover: press during alarm -> alarm=0, running=0; press with count zero -> no change.
REQ-037 SHALL cover: scan check -> seg_com cycles 8'h7F..8'hFE with matching seg_data; rst mid-run -> 8'hFF/8'h00 next cycle.

Source files
------------

// File: rtl/countdown_timer_pkg.sv
// countdown_timer_pkg: shared stopwatch constants and helpers for the countdown timer and its digit decoder.
package countdown_timer_pkg;
  typedef logic [3:0] bcd_t;
  localparam int NUM_DIGITS = 8;
  localparam bcd_t PSC_TC = 4'd9;
  localparam logic [31:0] DIGIT_LIMITS = 32'h9959_5999;
  localparam logic [7:0] BLANK_CODE = 8'h00;
  localparam logic [7:0] COM_OFF = 8'hFF;
  localparam int BLINK_HALF = 250;
  function automatic bcd_t digit_limit(input logic [2:0] i);
    return DIGIT_LIMITS[4 * (7 - int'(i)) +: 4];
  endfunction
  function automatic logic [7:0] com_pattern(input logic [2:0] i);
    return ~(8'h80 >> i);
  endfunction
  function automatic bcd_t clamp(input bcd_t v, input bcd_t lim);
    return v > lim ? lim : v;
  endfunction
endpackage

// File: rtl/countdown_timer_seg_decode.sv
// seg_decode: BCD digit to 7-segment pattern {dp,g,f,e,d,c,b,a}, blank for non-BCD codes.
module seg_decode
  import countdown_timer_pkg::*;
(
  input  bcd_t       bcd,
  output logic [7:0] seg
);
  always_comb begin
    case (bcd)
      4'd0: seg = 8'h3F;
      4'd1: seg = 8'h06;
      4'd2: seg = 8'h5B;
      4'd3: seg = 8'h4F;
      4'd4: seg = 8'h66;
      4'd5: seg = 8'h6D;
      4'd6: seg = 8'h7D;
      4'd7: seg = 8'h07;
      4'd8: seg = 8'h7F;
      4'd9: seg = 8'h6F;
      default: seg = BLANK_CODE;
    endcase
  end
endmodule

// File: rtl/countdown_timer.sv
// countdown_timer: HH:MM:SS:cs BCD countdown with scanned 7-seg display; define ALARM_BLINK_EN to blink the display during alarm.
module countdown_timer
  import countdown_timer_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        load,
  input  logic [23:0] preset,
  output logic [7:0]  seg_data,
  output logic [7:0]  seg_com,
  output logic        running,
  output logic        alarm
);
  bcd_t digit [NUM_DIGITS];
  bcd_t nxt [NUM_DIGITS];
  logic [7:0] seg [NUM_DIGITS];
  logic [3:0] psc;
  logic [2:0] scan;
  logic start_q, press, tick, nz, nxt_zero, blank;
  assign press = start & ~start_q;
  assign tick = running & (psc == PSC_TC);
  // Borrow ripples from cs_one upward; a zero digit wraps to its own limit.
  always_comb begin
    logic b;
    b = 1'b1;
    nz = 1'b0;
    nxt_zero = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      nxt[i] = b ? (digit[i] == 4'd0 ? digit_limit(3'(i)) : digit[i] - 4'd1) : digit[i];
      b = b & (digit[i] == 4'd0);
      nz = nz | (digit[i] != 4'd0);
      nxt_zero = nxt_zero & (nxt[i] == 4'd0);
    end
  end
  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_dec
    seg_decode u_dec (.bcd(digit[g]), .seg(seg[g]));
  end
`ifdef ALARM_BLINK_EN
  logic [7:0] blink_cnt;
  logic blink_off;
  always_ff @(posedge clk) begin
    if (rst || !alarm) begin
      blink_cnt <= '0;
      blink_off <= 1'b0;
    end else if (blink_cnt == 8'(BLINK_HALF - 1)) begin
      blink_cnt <= '0;
      blink_off <= ~blink_off;
    end else begin
      blink_cnt <= blink_cnt + 8'd1;
    end
  end
  assign blank = alarm & blink_off;
`else
  assign blank = 1'b0;
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_DIGITS; i++) digit[i] <= '0;
      psc <= '0;
      scan <= '0;
      running <= 1'b0;
      alarm <= 1'b0;
      start_q <= 1'b0;
      seg_data <= BLANK_CODE;
      seg_com <= COM_OFF;
    end else begin
      start_q <= start;
      scan <= scan + 3'd1;
      seg_data <= seg[scan];
      seg_com <= blank ? COM_OFF : com_pattern(scan);
      if (load) begin
        for (int i = 0; i < 6; i++) digit[i] <= clamp(preset[4 * (5 - i) +: 4], digit_limit(3'(i)));
        digit[6] <= '0;
        digit[7] <= '0;
        psc <= '0;
        running <= 1'b0;
        alarm <= 1'b0;
      end else begin
        if (press && alarm) alarm <= 1'b0;
        else if (press && nz) running <= ~running;
        if (running) psc <= tick ? 4'd0 : psc + 4'd1;
        if (tick) begin
          for (int i = 0; i < NUM_DIGITS; i++) digit[i] <= nxt[i];
          if (nxt_zero) begin
            running <= 1'b0;
            alarm <= 1'b1;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_countdown_timer.sv
// tb_countdown_timer: directed and random checks of countdown_timer against a centisecond-count reference model.
module tb_countdown_timer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic load = 1'b0;
  logic [23:0] preset = '0;
  logic [7:0] seg_data, seg_com;
  logic running, alarm;
  int n_checks = 0;
  int n_fail = 0;
  int m_cnt = 0, m_psc = 0, m_scan = 0;
  bit m_run = 0, m_alarm = 0, m_prev = 0;
  logic [7:0] e_com = 8'hFF, e_data = 8'h00;

  countdown_timer dut (
    .clk(clk), .rst(rst), .start(start), .load(load), .preset(preset),
    .seg_data(seg_data), .seg_com(seg_com), .running(running), .alarm(alarm)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] seg_tab(input int d);
    case (d)
      0: return 8'h3F;
      1: return 8'h06;
      2: return 8'h5B;
      3: return 8'h4F;
      4: return 8'h66;
      5: return 8'h6D;
      6: return 8'h7D;
      7: return 8'h07;
      8: return 8'h7F;
      9: return 8'h6F;
      default: return 8'h00;
    endcase
  endfunction

  function automatic int lim(input int v, input int l);
    return v > l ? l : v;
  endfunction

  function automatic int preset_cs(input logic [23:0] p);
    int h, m, s;
    h = lim(int'(p[23:20]), 9) * 10 + lim(int'(p[19:16]), 9);
    m = lim(int'(p[15:12]), 5) * 10 + lim(int'(p[11:8]), 9);
    s = lim(int'(p[7:4]), 5) * 10 + lim(int'(p[3:0]), 9);
    return ((h * 60 + m) * 60 + s) * 100;
  endfunction

  function automatic int digit_of(input int c, input int p);
    int h, m, s, cs;
    h = c / 360000;
    m = (c / 6000) % 60;
    s = (c / 100) % 60;
    cs = c % 100;
    case (p)
      0: return h / 10;
      1: return h % 10;
      2: return m / 10;
      3: return m % 10;
      4: return s / 10;
      5: return s % 10;
      6: return cs / 10;
      default: return cs % 10;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    bit press, was_run;
    @(posedge clk);
    press = start && !m_prev;
    if (rst) begin
      m_cnt = 0; m_psc = 0; m_scan = 0;
      m_run = 0; m_alarm = 0; m_prev = 0;
      e_com = 8'hFF; e_data = 8'h00;
    end else begin
      e_com = ~(8'h80 >> m_scan);
      e_data = seg_tab(digit_of(m_cnt, m_scan));
      m_scan = (m_scan + 1) % 8;
      m_prev = start;
      if (load) begin
        m_cnt = preset_cs(preset);
        m_psc = 0; m_run = 0; m_alarm = 0;
      end else begin
        was_run = m_run;
        if (press) begin
          if (m_alarm) m_alarm = 0;
          else if (m_cnt != 0) m_run = !m_run;
        end
        if (was_run) begin
          if (m_psc == 9) begin
            m_psc = 0;
            m_cnt--;
            if (m_cnt == 0) begin
              m_run = 0;
              m_alarm = 1;
            end
          end else m_psc++;
        end
      end
    end
    #1;
    chk("seg_com", 32'(seg_com), 32'(e_com));
    chk("seg_data", 32'(seg_data), 32'(e_data));
    chk("running", 32'(running), 32'(m_run));
    chk("alarm", 32'(alarm), 32'(m_alarm));
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic press();
    start = 1'b1;
    step();
    start = 1'b0;
    step();
  endtask

  task automatic do_load(input logic [23:0] p);
    preset = p;
    load = 1'b1;
    step();
    load = 1'b0;
  endtask

  task automatic read_display(input string tag, input logic [31:0] exp);
    logic [7:0] seen;
    seen = '0;
    for (int k = 0; k < 8; k++) begin
      step();
      for (int p = 0; p < 8; p++)
        if (seg_com == ~(8'h80 >> p)) begin
          seen[p] = 1'b1;
          chk(tag, 32'(seg_data), 32'(seg_tab(int'(exp[31 - 4 * p -: 4]))));
        end
    end
    chk({tag, "_scan"}, 32'(seen), 32'hFF);
  endtask

  initial begin
    cycles(2);
    chk("rst_com", 32'(seg_com), 32'hFF);
    chk("rst_data", 32'(seg_data), 32'h00);
    chk("rst_run", 32'(running), 32'd0);
    chk("rst_alarm", 32'(alarm), 32'd0);
    rst = 1'b0;
    do_load(24'h000001);
    press();
    chk("start_run", 32'(running), 32'd1);
    cycles(8);
    step();
    press();
    read_display("cs99", 32'h0000_0099);
    press();
    cycles(1000);
    chk("expire_alarm", 32'(alarm), 32'd1);
    chk("expire_run", 32'(running), 32'd0);
    press();
    chk("clr_alarm", 32'(alarm), 32'd0);
    chk("clr_run", 32'(running), 32'd0);
    press();
    chk("zero_run", 32'(running), 32'd0);
    chk("zero_alarm", 32'(alarm), 32'd0);
    do_load(24'h010000);
    press();
    cycles(8);
    step();
    press();
    read_display("ripple", 32'h0059_5999);
    do_load(24'h000010);
    press();
    cycles(349);
    press();
    cycles(200);
    read_display("pause", 32'h0000_0965);
    press();
    cycles(20);
    chk("resume_run", 32'(running), 32'd1);
    preset = 24'h007000;
    load = 1'b1;
    start = 1'b1;
    step();
    chk("load_pri_run", 32'(running), 32'd0);
    load = 1'b0;
    step();
    start = 1'b0;
    read_display("clamp", 32'h0050_0000);
    press();
    cycles(25);
    rst = 1'b1;
    step();
    chk("midrst_com", 32'(seg_com), 32'hFF);
    chk("midrst_data", 32'(seg_data), 32'h00);
    chk("midrst_run", 32'(running), 32'd0);
    rst = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      rst = ($urandom_range(0, 499) == 0);
      load = ($urandom_range(0, 59) == 0);
      if (load) preset = $urandom_range(0, 1) ? 24'($urandom) : {20'h0, 4'($urandom_range(0, 3))};
      if ($urandom_range(0, 11) == 0) start = ~start;
      step();
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
